// File: rtl/pri_encoder_hs_if.sv
// Handshake bundle for pri_encoder_hs: request lines and controls in, binary code out.
// The MULTI output exists only when PRI_ENCODER_HS_MULTI_EN is defined.
interface pri_encoder_hs_if #(
   parameter int N = 8,
   parameter int W = 3
);
   logic         en_i;
   logic         hl_i;
   logic [N-1:0] in_i;
   logic         ack_i;
   logic [W-1:0] out_o;
   logic         valid_o;
   logic         any_o;
`ifdef PRI_ENCODER_HS_MULTI_EN
   logic         multi_o;
`endif

`ifdef PRI_ENCODER_HS_MULTI_EN
   modport master (output en_i, hl_i, in_i, ack_i, input out_o, valid_o, any_o, multi_o);
   modport slave  (input en_i, hl_i, in_i, ack_i, output out_o, valid_o, any_o, multi_o);
`else
   modport master (output en_i, hl_i, in_i, ack_i, input out_o, valid_o, any_o);
   modport slave  (input en_i, hl_i, in_i, ack_i, output out_o, valid_o, any_o);
`endif
endinterface

// File: rtl/pri_encoder_hs.sv
// Sequential priority encoder: sticky pending register, highest index presented with VALID/ACK.
// Optional MULTI output enabled by defining PRI_ENCODER_HS_MULTI_EN.
//
// state     | meaning
// S_IDLE    | no code presented; selects from pending on the next edge
// S_PRESENT | OUT holds a code, VALID=1, waiting for ACK
module pri_encoder_hs #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   pri_encoder_hs_if.slave   bus
);

   typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] out_q, out_d;
   logic [N-1:0] req;
   logic [N-1:0] clr;
   logic [W-1:0] hi_idx;
`ifdef PRI_ENCODER_HS_MULTI_EN
   logic         multi_q, multi_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         out_q     <= '0;
`ifdef PRI_ENCODER_HS_MULTI_EN
         multi_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         out_q     <= out_d;
`ifdef PRI_ENCODER_HS_MULTI_EN
         multi_q   <= multi_d;
`endif
      end
   end

   // Highest set bit wins; later iterations overwrite earlier ones.
   always_comb begin
      hi_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (pending_q[i]) hi_idx = W'(i);
      end
   end

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
`ifdef PRI_ENCODER_HS_MULTI_EN
      multi_d   = multi_q;
`endif
      req       = bus.hl_i ? bus.in_i : ~bus.in_i;
      clr       = '0;
      if ((state_q == S_PRESENT) && bus.ack_i) clr = {{(N-1){1'b0}}, 1'b1} << out_q;
      // Set wins over clear when the served line is still requesting.
      pending_d = (pending_q & ~clr) | req;

      if (!bus.en_i) begin
         state_d   = S_IDLE;
         pending_d = '0;
         out_d     = '0;
`ifdef PRI_ENCODER_HS_MULTI_EN
         multi_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pending_q != '0) begin
                  state_d = S_PRESENT;
                  out_d   = hi_idx;
`ifdef PRI_ENCODER_HS_MULTI_EN
                  multi_d = (pending_q & (pending_q - 1'b1)) != '0;
`endif
               end
            end
            S_PRESENT: begin
               if (bus.ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.out_o   = out_q;
      bus.valid_o = (state_q == S_PRESENT);
      bus.any_o   = |pending_q;
`ifdef PRI_ENCODER_HS_MULTI_EN
      bus.multi_o = multi_q;
`endif
   end

endmodule
